// File: rtl/psum_sfu.sv
// Psum accumulator: pass 0 writes the vector 1 cycle after accepting it; later passes read, add and write over 3 cycles.
// in_ready is high only in ACCEPT/WRITE, and no state advances while in_valid is low.
module psum_sfu #(
  parameter int COL     = 8,
  parameter int PSUM_BW = 16,
  parameter int ADDR_W  = 11,
  parameter int PASS_W  = 4,
  parameter int SAT     = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [ADDR_W:0]          num_vec,
  input  logic [PASS_W-1:0]        num_pass,
  input  logic                     relu_en,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [COL*PSUM_BW-1:0]   in_data,
  output logic                     mem_cen,
  output logic                     mem_wen,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [COL*PSUM_BW-1:0]   mem_d,
  input  logic [COL*PSUM_BW-1:0]   mem_q,
  output logic                     out_valid,
  output logic [COL*PSUM_BW-1:0]   out_data,
  output logic                     busy,
  output logic                     done
);

  localparam int VW = COL * PSUM_BW;
  localparam logic [ADDR_W:0]        ONE_V = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [PASS_W-1:0]      ONE_P = {{(PASS_W-1){1'b0}}, 1'b1};
  localparam logic [PSUM_BW-1:0]     SMAX  = {1'b0, {(PSUM_BW-1){1'b1}}};
  localparam logic [PSUM_BW-1:0]     SMIN  = {1'b1, {(PSUM_BW-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ACCEPT, READ, ADD, WRITE, DONE} state_t;

  state_t              state, nxt;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W:0]     num_vec_q, vec_cnt;
  logic [PASS_W-1:0]   num_pass_q, pass_cnt;
  logic                relu_q, fin_lat, last_lat, last_nxt;
  logic [VW-1:0]       in_lat;

  logic                xfer, vec_end, fin_pass, last_xfer, cfg_empty;
  logic [ADDR_W-1:0]   xfer_addr;
  logic [VW-1:0]       wr0_vec, sum_vec;

  function automatic logic [VW-1:0] relu_vec(input logic [VW-1:0] v, input logic en);
    logic [VW-1:0] r;
    r = v;
    for (int c = 0; c < COL; c++) begin
      if (en && v[c*PSUM_BW + PSUM_BW-1]) r[c*PSUM_BW +: PSUM_BW] = '0;
    end
    return r;
  endfunction

  // One guard bit per channel exposes signed overflow for the clamp.
  function automatic logic [VW-1:0] add_vec(input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic [VW-1:0]      r;
    logic [PSUM_BW:0]   s;
    r = '0;
    for (int c = 0; c < COL; c++) begin
      s = {a[c*PSUM_BW + PSUM_BW-1], a[c*PSUM_BW +: PSUM_BW]} +
          {b[c*PSUM_BW + PSUM_BW-1], b[c*PSUM_BW +: PSUM_BW]};
      if (SAT != 0 && s[PSUM_BW] != s[PSUM_BW-1])
        r[c*PSUM_BW +: PSUM_BW] = s[PSUM_BW] ? SMIN : SMAX;
      else
        r[c*PSUM_BW +: PSUM_BW] = s[PSUM_BW-1:0];
    end
    return r;
  endfunction

  assign xfer      = in_valid & in_ready;
  assign vec_end   = (vec_cnt == num_vec_q - ONE_V);
  assign fin_pass  = (pass_cnt == num_pass_q - ONE_P);
  assign last_xfer = vec_end & fin_pass;
  assign cfg_empty = (num_vec == '0) || (num_pass == '0);
  assign xfer_addr = base_q + vec_cnt[ADDR_W-1:0];
  assign wr0_vec   = relu_vec(in_data, fin_pass & relu_q);
  assign sum_vec   = relu_vec(add_vec(mem_q, in_lat), fin_lat & relu_q);

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = cfg_empty ? DONE : ACCEPT;
      ACCEPT:  if (xfer) begin
                 if (pass_cnt != '0) nxt = READ;
                 else if (last_xfer) nxt = WRITE;
               end
      READ:    nxt = ADD;
      ADD:     nxt = WRITE;
      WRITE:   if (last_lat) nxt = DONE;
               else if (xfer) nxt = READ;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    last_nxt = last_lat;
    if (state == IDLE && start) last_nxt = 1'b0;
    else if (xfer) last_nxt = last_xfer;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      base_q     <= '0;
      num_vec_q  <= '0;
      num_pass_q <= '0;
      relu_q     <= 1'b0;
      vec_cnt    <= '0;
      pass_cnt   <= '0;
      fin_lat    <= 1'b0;
      last_lat   <= 1'b0;
      in_lat     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      mem_cen    <= 1'b1;
      mem_wen    <= 1'b1;
      mem_addr   <= '0;
      mem_d      <= '0;
    end else begin
      state     <= nxt;
      busy      <= (nxt != IDLE);
      done      <= (nxt == DONE);
      in_ready  <= (nxt == ACCEPT) || (nxt == WRITE && !last_nxt);
      last_lat  <= last_nxt;
      mem_cen   <= 1'b1;
      mem_wen   <= 1'b1;
      out_valid <= 1'b0;

      if (state == IDLE && start) begin
        base_q     <= base_addr;
        num_vec_q  <= num_vec;
        num_pass_q <= num_pass;
        relu_q     <= relu_en;
        vec_cnt    <= '0;
        pass_cnt   <= '0;
      end

      if (xfer) begin
        mem_cen  <= 1'b0;
        mem_addr <= xfer_addr;
        fin_lat  <= fin_pass;
        vec_cnt  <= vec_end ? '0 : vec_cnt + ONE_V;
        if (vec_end) pass_cnt <= pass_cnt + ONE_P;
        // Pass 0 has nothing to accumulate: write straight through.
        if (pass_cnt == '0) begin
          mem_wen   <= 1'b0;
          mem_d     <= wr0_vec;
          out_valid <= fin_pass;
          if (fin_pass) out_data <= wr0_vec;
        end else begin
          in_lat <= in_data;
        end
      end

      if (state == ADD) begin
        mem_cen   <= 1'b0;
        mem_wen   <= 1'b0;
        mem_d     <= sum_vec;
        out_valid <= fin_lat;
        if (fin_lat) out_data <= sum_vec;
      end
    end
  end

endmodule

// File: doc/psum_sfu.md
PSUM_SFU -- requirements
Module: psum_sfu

Interface
REQ-001 SHALL have parameter COL, default 8: number of output channels.
REQ-002 SHALL have parameter PSUM_BW, default 16: signed psum width per channel.
REQ-003 SHALL have parameter ADDR_W, default 11: psum SRAM address width (2048 words).
REQ-004 SHALL have parameter PASS_W, default 4: width of the pass counter.
REQ-005 SHALL have parameter SAT, default 1: 1 = saturating add, 0 = wrap-around add.
REQ-006 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have ports start (in, 1: config-latch pulse), base_addr (in, ADDR_W), num_vec (in, ADDR_W+1), num_pass (in, PASS_W) and relu_en (in, 1).
REQ-009 SHALL have ports in_valid (in, 1), in_ready (out, 1) and in_data (in, COL*PSUM_BW): the OFIFO vector stream, channel c at bits [c*PSUM_BW +: PSUM_BW].
REQ-010 SHALL have ports mem_cen (out, 1, active-low), mem_wen (out, 1, active-low write), mem_addr (out, ADDR_W), mem_d (out, COL*PSUM_BW) and mem_q (in, COL*PSUM_BW) to the psum SRAM; mem_q is valid the cycle after a read edge.
REQ-011 SHALL have ports out_valid (out, 1), out_data (out, COL*PSUM_BW), busy (out, 1) and done (out, 1).

Function
REQ-012 SHALL drive all outputs from registers.
REQ-013 SHALL use FSM states IDLE, ACCEPT, READ, ADD, WRITE and DONE.
REQ-014 SHALL, in IDLE, ignore input and hold in_ready=0.
REQ-015 SHALL, on start in IDLE, latch the config inputs, clear vec_cnt and pass_cnt, and go to ACCEPT.
REQ-016 SHALL, on start in IDLE with num_vec==0 or num_pass==0, go directly to DONE with no SRAM access.
REQ-017 SHALL ignore start while busy.
REQ-018 SHALL set busy=1 in every state except IDLE.
REQ-019 SHALL drive in_ready=1 in ACCEPT and in WRITE, and 0 in all other states.
REQ-020 SHALL form the transfer address as base_addr+vec_cnt modulo 2^ADDR_W (wraps).
REQ-021 SHALL, on a pass-0 transfer at edge T, write in_data at T+1 (mem_cen=0, mem_wen=0) and stay in ACCEPT, giving 1 vector/cycle.
REQ-022 SHALL, on a pass>0 transfer at edge T, issue a read at T+1 (READ: mem_cen=0, mem_wen=1), register the channel-wise sum of mem_q and the latched input at T+2 (ADD), and write the sum at T+3 (WRITE), giving 1 vector per 3 cycles.
REQ-023 SHALL allow a transfer in WRITE to start the next READ with no bubble.
REQ-024 SHALL add each channel as signed PSUM_BW; with SAT=1 it saturates to [-2^(PSUM_BW-1), 2^(PSUM_BW-1)-1], with SAT=0 it wraps.
REQ-025 SHALL, on the final pass (pass_cnt==num_pass-1) with relu_en=1, write 0 for every negative channel.
REQ-026 SHALL, on every final-pass write, pulse out_valid=1 with out_data equal to mem_d in the same cycle.
REQ-027 SHALL hold out_valid=0 at all other times.
REQ-028 SHALL increment vec_cnt per transfer; at num_vec-1 it clears vec_cnt and increments pass_cnt.
REQ-029 SHALL, after the final write of the final pass, hold in_ready=0, go to DONE, pulse done=1 for one cycle, and return to IDLE.
REQ-030 SHALL keep mem_cen=1 and mem_wen=1 in any cycle with no access, so that no read and write are issued in the same cycle.
REQ-031 SHALL not advance state while in_valid=0 in ACCEPT or WRITE, other than completing that WRITE's SRAM write.

Reset
REQ-032 SHALL, on reset low, asynchronously force IDLE, clear counters, and set busy=0, done=0, out_valid=0, in_ready=0, mem_cen=1, mem_wen=1, mem_addr=0, mem_d=0 and out_data=0.
REQ-033 SHALL, on reset mid-operation, abort any in-flight read or write with no further SRAM access.
REQ-034 SHALL, after a mid-operation reset, require a new start to resume.

Verification
REQ-035 SHALL be verified for a single pass: base=5, num_vec=3, num_pass=1, relu_en=1, channel 0 inputs {-3, 7, 0} -> SRAM writes at 5, 6, 7 of {0, 7, 0}, three out_valid pulses, then done.
REQ-036 SHALL be verified for accumulation: num_vec=2, num_pass=3, every input all-ones (+1) -> final SRAM contents 3 on all channels, read→write spacing of 2 cycles, out_valid only on pass 2.
REQ-037 SHALL be verified for saturation: SAT=1, stored 32760 plus input 100 -> 32767; with SAT=0 the same stimulus -> -32676.
REQ-038 SHALL be verified for wrap and degenerate config: base=2046, num_vec=4 -> addresses 2046, 2047, 0, 1; num_vec=0 -> done one cycle after IDLE exit, no mem_cen=0 cycles.
REQ-039 SHALL be verified for backpressure and restart: in_valid toggled 1/0 during pass 1 -> correct sums with no extra SRAM accesses; start pulsed while busy -> ignored.
REQ-040 SHALL be verified for reset abort: reset asserted in ADD -> mem_cen=1 immediately, busy=0; a subsequent fresh start completes normally.
